// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI-Lite subordinate exposing a bank of 32-bit control/status registers
//
// Purpose:
//   Terminates one AXI-Lite master port. NUM_REGS word registers are decoded
//   from addr[LOCAL_AW-1:2]. Each register is either read/write (held in flops,
//   driven by the bus) or read-only (RO_MASK bit set, value sampled from
//   hw_status_i). Per-register one-cycle write/read strobes let peripherals
//   build write-triggered and clear-on-read behaviour.
//
// Optional feature macro: AXIL_REG_SLAVE_DECERR_EN
//   defined     : out-of-range accesses answer SLVERR (reads return 0)
//   not defined : out-of-range accesses answer OKAY (writes dropped, reads 0)
//
// Ports:
//   clk_i, reset_i                   clock, synchronous active-high reset
//   s_axil_aw* / s_axil_w* / s_axil_b*   AXI-Lite write address, data, response
//   s_axil_ar* / s_axil_r*           AXI-Lite read address and data/response
//   reg_q_o      [NUM_REGS*32]       current RW register values (RO slots 0)
//   hw_status_i  [NUM_REGS*32]       hardware values returned for RO registers
//   wr_pulse_o   [NUM_REGS]          one-cycle strobe: RW register i written
//   rd_pulse_o   [NUM_REGS]          one-cycle strobe: register i read

module axil_reg_slave #(
   parameter int                               NUM_REGS   = 16,
   parameter int                               DATA_WIDTH = 32,
   parameter int                               ADDR_WIDTH = 32,
   parameter int                               LOCAL_AW   = 12,
   parameter logic [NUM_REGS-1:0]              RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
   input  logic                             clk_i,
   input  logic                             reset_i,

   input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
   input  logic [2:0]                       s_axil_awprot,
   input  logic                             s_axil_awvalid,
   output logic                             s_axil_awready,

   input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
   input  logic [DATA_WIDTH/8-1:0]          s_axil_wstrb,
   input  logic                             s_axil_wvalid,
   output logic                             s_axil_wready,

   output logic [1:0]                       s_axil_bresp,
   output logic                             s_axil_bvalid,
   input  logic                             s_axil_bready,

   input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
   input  logic [2:0]                       s_axil_arprot,
   input  logic                             s_axil_arvalid,
   output logic                             s_axil_arready,

   output logic [DATA_WIDTH-1:0]            s_axil_rdata,
   output logic [1:0]                       s_axil_rresp,
   output logic                             s_axil_rvalid,
   input  logic                             s_axil_rready,

   output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_status_i,
   output logic [NUM_REGS-1:0]              wr_pulse_o,
   output logic [NUM_REGS-1:0]              rd_pulse_o
);

   localparam int          STRB_WIDTH = DATA_WIDTH / 8;
   localparam int          IDX_W      = LOCAL_AW - 2;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
`ifdef AXIL_REG_SLAVE_DECERR_EN
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
`endif

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic                    aw_held_q, aw_held_d;
   logic [IDX_W-1:0]        aw_idx_q,  aw_idx_d;
   logic                    w_held_q,  w_held_d;
   logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q,   wstrb_d;
   logic                    bvalid_q,  bvalid_d;
   logic [1:0]              bresp_q,   bresp_d;
   logic                    rvalid_q,  rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
   logic [1:0]              rresp_q,   rresp_d;
   logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
   logic [NUM_REGS-1:0]     rd_pulse_q, rd_pulse_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

   // ---------------------------------------------------------------
   // Handshakes and decode
   // ---------------------------------------------------------------
   logic                    aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]        wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [STRB_WIDTH-1:0]   wr_strb;
   logic                    wr_in_range, rd_in_range;

   assign s_axil_awready = !aw_held_q && !bvalid_q;
   assign s_axil_wready  = !w_held_q  && !bvalid_q;
   assign s_axil_arready = !rvalid_q;

   assign aw_hs = s_axil_awvalid && s_axil_awready;
   assign w_hs  = s_axil_wvalid  && s_axil_wready;
   assign ar_hs = s_axil_arvalid && s_axil_arready;

   // A beat arriving this cycle counts as held, so the commit happens on the
   // same edge as the later of the two handshakes (B appears one cycle later).
   assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
   assign wr_idx  = aw_held_q ? aw_idx_q : s_axil_awaddr[LOCAL_AW-1:2];
   assign wr_data = w_held_q  ? wdata_q  : s_axil_wdata;
   assign wr_strb = w_held_q  ? wstrb_q  : s_axil_wstrb;
   assign rd_idx  = s_axil_araddr[LOCAL_AW-1:2];

   // Extra top bit keeps the compare correct when NUM_REGS == 2**IDX_W.
   assign wr_in_range = {1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS);
   assign rd_in_range = {1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS);

   // Bits the interconnect already decoded, protection attributes and the
   // range flags (consumed only by the error-response build).
   logic unused_ok;
   assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                        s_axil_awaddr[ADDR_WIDTH-1:LOCAL_AW], s_axil_awaddr[1:0],
                        s_axil_araddr[ADDR_WIDTH-1:LOCAL_AW], s_axil_araddr[1:0],
                        wr_in_range, rd_in_range};

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      wr_pulse_d = '0;
      rd_pulse_d = '0;
      regs_d     = regs_q;

      // Write path: capture beats independently into the holding registers.
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = s_axil_awaddr[LOCAL_AW-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axil_wdata;
         wstrb_d  = s_axil_wstrb;
      end

      if (bvalid_q && s_axil_bready) begin
         bvalid_d = 1'b0;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            // RO registers swallow the write silently: no update, no strobe.
            if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (wr_strb[b]) begin
                     regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                  end
               end
               wr_pulse_d[i] = 1'b1;
            end
         end
`ifdef AXIL_REG_SLAVE_DECERR_EN
         if (!wr_in_range) begin
            bresp_d = RESP_SLVERR;
         end
`endif
      end

      // Read path: one outstanding read; data sampled on the AR edge, so a
      // same-edge write commit to the same register is not yet visible.
      if (rvalid_q && s_axil_rready) begin
         rvalid_d = 1'b0;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
               rdata_d       = RO_MASK[i] ? hw_status_i[i*DATA_WIDTH +: DATA_WIDTH]
                                          : regs_q[i];
               rd_pulse_d[i] = 1'b1;
            end
         end
`ifdef AXIL_REG_SLAVE_DECERR_EN
         if (!rd_in_range) begin
            rresp_d = RESP_SLVERR;
         end
`endif
      end
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         rd_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end else begin
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         wr_pulse_q <= wr_pulse_d;
         rd_pulse_q <= rd_pulse_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = bresp_q;
   assign s_axil_rvalid = rvalid_q;
   assign s_axil_rdata  = rdata_q;
   assign s_axil_rresp  = rresp_q;
   assign wr_pulse_o    = wr_pulse_q;
   assign rd_pulse_o    = rd_pulse_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
      assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
   end

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - self-checking bench for axil_reg_slave

module tb_axil_reg_slave;

   localparam int            NR = 16;
   localparam logic [15:0]   RO = 16'h0008;
   localparam logic [511:0]  RV = (512'h0F0F0F0F << (15*32)) | (512'hCAFEF00D << (5*32))
                                | (512'h33333333 << (3*32))  | 512'h11111111;
`ifdef AXIL_REG_SLAVE_DECERR_EN
   localparam logic [1:0]    OOR_RESP = 2'b10;
`else
   localparam logic [1:0]    OOR_RESP = 2'b00;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   awaddr, wdata, araddr, rdata;
   logic [2:0]    awprot, arprot;
   logic [3:0]    wstrb;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [1:0]    bresp, rresp;
   logic [511:0]  reg_q, hw_status;
   logic [15:0]   wr_pulse, rd_pulse;

   int total = 0;
   int bad   = 0;
   logic [31:0] mregs [NR];

   always #5 clk = ~clk;

   axil_reg_slave #(
      .NUM_REGS(16), .DATA_WIDTH(32), .ADDR_WIDTH(32), .LOCAL_AW(12),
      .RO_MASK(RO), .RESET_VAL(RV)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .reg_q_o(reg_q), .hw_status_i(hw_status), .wr_pulse_o(wr_pulse), .rd_pulse_o(rd_pulse)
   );

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < NR; i++) mregs[i] = RV[i*32 +: 32];
   endtask

   function automatic int aidx(input logic [31:0] a);
      return int'(a[11:2]);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      i = aidx(a);
      if (i < NR && !RO[i])
         for (int b = 0; b < 4; b++) if (s[b]) mregs[i][b*8 +: 8] = d[b*8 +: 8];
   endtask

   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      int i;
      i = aidx(a);
      if (i >= NR) return 32'h0;
      if (RO[i]) return hw_status[i*32 +: 32];
      return mregs[i];
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      return (aidx(a) < NR) ? 2'b00 : OOR_RESP;
   endfunction

   function automatic logic [15:0] exp_wpulse(input logic [31:0] a);
      int i;
      i = aidx(a);
      return (i < NR && !RO[i]) ? (16'h1 << i) : 16'h0;
   endfunction

   function automatic logic [15:0] exp_rpulse(input logic [31:0] a);
      int i;
      i = aidx(a);
      return (i < NR) ? (16'h1 << i) : 16'h0;
   endfunction

   function automatic logic [511:0] exp_regq();
      logic [511:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) if (!RO[i]) v[i*32 +: 32] = mregs[i];
      return v;
   endfunction

   // ---------------- bus drivers (no checking) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_start, input int w_start,
                            output logic [1:0] resp, output int lat, output logic [15:0] pulse,
                            output int pcyc, output bit tmo);
      bit aw_done, w_done, a, w;
      int hs_c;
      aw_done = 0; w_done = 0; hs_c = 0;
      resp = 2'bxx; lat = -1; pulse = '0; pcyc = 0; tmo = 1;
      for (int c = 0; c < 40; c++) begin
         if (c == aw_start) begin awaddr = addr; awvalid = 1'b1; end
         if (c == w_start)  begin wdata = data; wstrb = strb; wvalid = 1'b1; end
         a = awvalid && awready;
         w = wvalid && wready;
         tick();
         if (a) begin awvalid = 1'b0; aw_done = 1; hs_c = c; end
         if (w) begin wvalid = 1'b0; w_done = 1; hs_c = c; end
         if (wr_pulse != 0) begin pulse |= wr_pulse; pcyc++; end
         if (aw_done && w_done && bvalid) begin
            resp = bresp; lat = c - hs_c + 1; bready = 1'b1;
            tick();
            bready = 1'b0;
            if (wr_pulse != 0) begin pulse |= wr_pulse; pcyc++; end
            tmo = 0;
            break;
         end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!tmo) model_write(addr, data, strb);
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output logic [15:0] pulse, output int pcyc, output bit tmo);
      bit a;
      int hs_c;
      hs_c = 0; data = 'x; resp = 2'bxx; lat = -1; pulse = '0; pcyc = 0; tmo = 1;
      araddr = addr; arvalid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         a = arvalid && arready;
         tick();
         if (a) begin arvalid = 1'b0; hs_c = c; end
         if (rd_pulse != 0) begin pulse |= rd_pulse; pcyc++; end
         if (!arvalid && rvalid) begin
            data = rdata; resp = rresp; lat = c - hs_c + 1; rready = 1'b1;
            tick();
            rready = 1'b0;
            if (rd_pulse != 0) begin pulse |= rd_pulse; pcyc++; end
            tmo = 0;
            break;
         end
      end
      arvalid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL reset_ready: got %b exp 111", {awready, wready, arready}); end
      total++; if ({bvalid, rvalid} !== 2'b00) begin bad++; $display("FAIL reset_valid: got %b exp 00", {bvalid, rvalid}); end
      total++; if ({bresp, rresp, rdata} !== 36'h0) begin bad++; $display("FAIL reset_resp_data: got %h exp 0", {bresp, rresp, rdata}); end
      total++; if ({wr_pulse, rd_pulse} !== 32'h0) begin bad++; $display("FAIL reset_pulses: got %h exp 0", {wr_pulse, rd_pulse}); end
      total++; if (reg_q !== exp_regq()) begin bad++; $display("FAIL reset_regs: got %h exp %h", reg_q, exp_regq()); end
   endtask

   task automatic test_same_cycle();
      logic [1:0] r; int lat, pc; logic [15:0] p; bit tmo;
      axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, r, lat, p, pc, tmo);
      total++; if (tmo || r !== 2'b00) begin bad++; $display("FAIL same_cycle_bresp: got %b tmo=%0d exp 00", r, tmo); end
      total++; if (lat !== 1) begin bad++; $display("FAIL same_cycle_latency: got %0d exp 1", lat); end
      total++; if (p !== 16'h0002 || pc !== 1) begin bad++; $display("FAIL same_cycle_pulse: got %h x%0d exp 0002 x1", p, pc); end
      total++; if (reg_q[32 +: 32] !== 32'hDEADBEEF) begin bad++; $display("FAIL same_cycle_reg1: got %h exp deadbeef", reg_q[32 +: 32]); end
   endtask

   task automatic test_w_first();
      logic [1:0] r; int lat, pc; logic [15:0] p; bit tmo;
      axi_write(32'h8, 32'h12345678, 4'b0101, 2, 0, r, lat, p, pc, tmo);
      total++; if (tmo || r !== 2'b00) begin bad++; $display("FAIL w_first_bresp: got %b tmo=%0d exp 00", r, tmo); end
      total++; if (lat !== 1) begin bad++; $display("FAIL w_first_latency: got %0d exp 1", lat); end
      total++; if (reg_q[64 +: 32] !== 32'h00340078) begin bad++; $display("FAIL w_first_reg2: got %h exp 00340078", reg_q[64 +: 32]); end
      total++; if (p !== 16'h0004 || pc !== 1) begin bad++; $display("FAIL w_first_pulse: got %h x%0d exp 0004 x1", p, pc); end
   endtask

   task automatic test_b_stall();
      logic [31:0] d1, d2;
      d1 = $urandom; d2 = $urandom;
      awaddr = 32'h18; wdata = d1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      tick();
      model_write(32'h18, d1, 4'hF);
      // second write offered while B is stalled; it must not be taken yet
      awaddr = 32'h1C; wdata = d2; wstrb = 4'hF;
      total++; if (bvalid !== 1'b1 || wr_pulse !== 16'h0040) begin bad++; $display("FAIL stall_first: got bvalid=%b pulse=%h exp 1 0040", bvalid, wr_pulse); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
            bad++; $display("FAIL stall_hold%0d: got bv=%b br=%b awr=%b wr=%b exp 1 00 0 0", i, bvalid, bresp, awready, wready);
         end
         tick();
         total++; if (wr_pulse !== 16'h0) begin bad++; $display("FAIL stall_pulse%0d: got %h exp 0", i, wr_pulse); end
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      total++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin bad++; $display("FAIL stall_release: got bv=%b awr=%b wr=%b exp 0 1 1", bvalid, awready, wready); end
      total++; if (reg_q[224 +: 32] !== mregs[7]) begin bad++; $display("FAIL stall_no_early_write: got %h exp %h", reg_q[224 +: 32], mregs[7]); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      model_write(32'h1C, d2, 4'hF);
      total++; if (bvalid !== 1'b1 || reg_q[224 +: 32] !== d2) begin bad++; $display("FAIL stall_next_write: got bv=%b reg7=%h exp 1 %h", bvalid, reg_q[224 +: 32], d2); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic test_ro();
      logic [31:0] d; logic [1:0] r; int lat, pc; logic [15:0] p; bit tmo;
      hw_status[96 +: 32] = 32'hA5A5A5A5;
      axi_read(32'hC, d, r, lat, p, pc, tmo);
      total++; if (tmo || d !== 32'hA5A5A5A5 || r !== 2'b00) begin bad++; $display("FAIL ro_read: got %h/%b tmo=%0d exp a5a5a5a5/00", d, r, tmo); end
      total++; if (p !== 16'h0008 || pc !== 1 || lat !== 1) begin bad++; $display("FAIL ro_read_pulse: got %h x%0d lat=%0d exp 0008 x1 lat=1", p, pc, lat); end
      axi_write(32'hC, $urandom, 4'hF, 0, 0, r, lat, p, pc, tmo);
      total++; if (tmo || r !== 2'b00 || p !== 16'h0) begin bad++; $display("FAIL ro_write: got resp=%b pulse=%h tmo=%0d exp 00 0000", r, p, tmo); end
      total++; if (reg_q !== exp_regq()) begin bad++; $display("FAIL ro_write_regs: got %h exp %h", reg_q, exp_regq()); end
      axi_read(32'hC, d, r, lat, p, pc, tmo);
      total++; if (tmo || d !== 32'hA5A5A5A5) begin bad++; $display("FAIL ro_reread: got %h exp a5a5a5a5", d); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d; logic [1:0] r; int lat, pc; logic [15:0] p; bit tmo;
      axi_read(32'h40, d, r, lat, p, pc, tmo);
      total++; if (tmo || r !== OOR_RESP || d !== 32'h0) begin bad++; $display("FAIL oor_read: got %h/%b tmo=%0d exp 0/%b", d, r, tmo, OOR_RESP); end
      total++; if (p !== 16'h0) begin bad++; $display("FAIL oor_read_pulse: got %h exp 0", p); end
      axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 1, r, lat, p, pc, tmo);
      total++; if (tmo || r !== OOR_RESP || p !== 16'h0) begin bad++; $display("FAIL oor_write: got %b pulse=%h exp %b 0000", r, p, OOR_RESP); end
      total++; if (reg_q !== exp_regq()) begin bad++; $display("FAIL oor_write_regs: got %h exp %h", reg_q, exp_regq()); end
   endtask

   task automatic test_same_edge();
      logic [31:0] oldv, newv;
      oldv = mregs[5]; newv = ~oldv;
      awaddr = 32'h14; araddr = 32'h14; wdata = newv; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      model_write(32'h14, newv, 4'hF);
      total++; if (rvalid !== 1'b1 || rdata !== oldv) begin bad++; $display("FAIL same_edge_rdata: got rv=%b %h exp 1 %h", rvalid, rdata, oldv); end
      total++; if (bvalid !== 1'b1 || reg_q[160 +: 32] !== newv) begin bad++; $display("FAIL same_edge_write: got bv=%b %h exp 1 %h", bvalid, reg_q[160 +: 32], newv); end
      total++; if (wr_pulse !== 16'h0020 || rd_pulse !== 16'h0020) begin bad++; $display("FAIL same_edge_pulses: got %h %h exp 0020 0020", wr_pulse, rd_pulse); end
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] a, d, got; logic [3:0] s; logic [1:0] r; int lat, pc; logic [15:0] p; bit tmo;
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < NR; i++) hw_status[i*32 +: 32] = $urandom;
         a = {$urandom_range(0, 32'hFFFFF), 10'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 0) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r, lat, p, pc, tmo);
            total++;
            if (tmo || r !== exp_resp(a) || lat !== 1 || p !== exp_wpulse(a) || pc !== ((exp_wpulse(a) != 0) ? 1 : 0) || reg_q !== exp_regq()) begin
               bad++; $display("FAIL rand_write%0d a=%h: got resp=%b lat=%0d pulse=%h x%0d tmo=%0d exp resp=%b lat=1 pulse=%h", n, a, r, lat, p, pc, tmo, exp_resp(a), exp_wpulse(a));
            end
         end else begin
            axi_read(a, got, r, lat, p, pc, tmo);
            total++;
            if (tmo || got !== exp_rdata(a) || r !== exp_resp(a) || lat !== 1 || p !== exp_rpulse(a) || pc !== ((exp_rpulse(a) != 0) ? 1 : 0)) begin
               bad++; $display("FAIL rand_read%0d a=%h: got %h/%b lat=%0d pulse=%h x%0d exp %h/%b pulse=%h", n, a, got, r, lat, p, pc, exp_rdata(a), exp_resp(a), exp_rpulse(a));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      awaddr = 32'h24; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      araddr = 32'h0; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      total++; if (rvalid !== 1'b1 || awready !== 1'b0) begin bad++; $display("FAIL mid_setup: got rv=%b awr=%b exp 1 0", rvalid, awready); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      total++; if ({bvalid, rvalid, rdata} !== 34'h0) begin bad++; $display("FAIL mid_reset_valids: got %h exp 0", {bvalid, rvalid, rdata}); end
      total++; if (reg_q !== exp_regq()) begin bad++; $display("FAIL mid_reset_regs: got %h exp %h", reg_q, exp_regq()); end
      // a lone W must not pair with the AW dropped by reset
      wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (wready) begin tick(); wvalid = 1'b0; end else tick();
         total++; if (bvalid !== 1'b0 || wr_pulse !== 16'h0) begin bad++; $display("FAIL mid_no_b%0d: got bv=%b pulse=%h exp 0 0", i, bvalid, wr_pulse); end
      end
      wvalid = 1'b0;
      apply_reset();
   endtask

   initial begin
      reset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      hw_status = '0;
      model_reset();
      repeat (2) tick();
      test_reset();
      test_same_cycle();
      test_w_first();
      test_b_stall();
      test_ro();
      test_out_of_range();
      test_same_edge();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
